// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared definitions for the shift-and-add multiplier slice.
//             Holds the controller state encoding, the nibble width of the
//             ripple adder building block and the operand-width check macro.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of one ripple adder building block.
    localparam int unsigned C_NIBBLE_W = 4;

endpackage

// Elaboration-time guard: the adder chain is built purely from 4-bit
// slices, so operand widths that are not a multiple of 4 cannot be mapped.
`ifndef MULT_WIDTH_CHECK
`define MULT_WIDTH_CHECK(W) \
    if (((W) % 4) != 0) begin : g_width_check \
        $error("WIDTH must be a multiple of 4"); \
    end
`endif

`default_nettype wire

// File: rtl/four_bit_adder.sv
`default_nettype none
// ============================================================================
//  Module   : four_bit_adder
//  Purpose  : 4-bit ripple-carry adder built from full-adder cells.
//  Ports    : a, b  - 4-bit addends
//             cin   - carry in
//             sum   - 4-bit sum
//             cout  - carry out of bit 3
//  Revision : 1.0 - initial release
// ============================================================================
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar g = 0; g < 4; g++) begin : g_bit
        assign sum[g]       = a[g] ^ b[g] ^ w_carry[g];
        assign w_carry[g+1] = (a[g] & b[g]) | (w_carry[g] & (a[g] ^ b[g]));
    end

    assign cout = w_carry[4];

endmodule

`default_nettype wire

// File: rtl/mult_adder_chain.sv
`default_nettype none
// ============================================================================
//  Module   : mult_adder_chain
//  Purpose  : WIDTH-bit adder formed by chaining WIDTH/4 four_bit_adder
//             slices; carry ripples from the low nibble upwards, Cin = 0.
//  Ports    : a, b  - WIDTH-bit addends
//             sum   - WIDTH-bit sum
//             cout  - carry out of the top nibble
//  Revision : 1.0 - initial release
// ============================================================================
module mult_adder_chain
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    `MULT_WIDTH_CHECK(WIDTH)

    localparam int C_N_SLICES = WIDTH / C_NIBBLE_W;

    logic [C_N_SLICES:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar g = 0; g < C_N_SLICES; g++) begin : g_nibble
        four_bit_adder u_add (
            .a    (a[4*g +: 4]),
            .b    (b[4*g +: 4]),
            .cin  (w_carry[g]),
            .sum  (sum[4*g +: 4]),
            .cout (w_carry[g+1])
        );
    end

    assign cout = w_carry[C_N_SLICES];

endmodule

`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult_ctrl
//  Purpose  : Sequential shift-and-add unsigned multiplier. Accepts one
//             operand pair over valid/ready, performs one add-or-shift step
//             per clock for WIDTH clocks, then holds the 2*WIDTH-bit product
//             until the consumer accepts it.
//  Ports    : i_clk, i_rst_n      - clock, async active-low reset
//             i_valid / o_ready   - operand handshake (i_a, i_b)
//             i_clear             - synchronous abort back to IDLE
//             o_valid / i_ready   - product handshake (o_product)
//             o_busy              - iteration in progress
//  Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_clear,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*WIDTH-1:0]   o_product,
    output logic                 o_busy
);

    `MULT_WIDTH_CHECK(WIDTH)

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     w_mcand_nxt;
    logic [2*WIDTH-1:0]   r_p;
    logic [2*WIDTH-1:0]   w_p_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic                 w_last;

    // Upper half of P accumulates; the multiplier bit under test is P[0].
    assign w_addend = r_p[0] ? r_mcand : '0;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    mult_adder_chain #(
        .WIDTH (WIDTH)
    ) u_chain (
        .a    (r_p[2*WIDTH-1:WIDTH]),
        .b    (w_addend),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_mcand <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mcand <= w_mcand_nxt;
            r_p     <= w_p_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mcand_nxt = r_mcand;
        w_p_nxt     = r_p;
        w_cnt_nxt   = r_cnt;

        if (i_clear) begin
            // Abort wins over everything, including a same-cycle accept.
            w_state_nxt = ST_IDLE;
            w_p_nxt     = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        w_mcand_nxt = i_a;
                        w_p_nxt     = {{WIDTH{1'b0}}, i_b};
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Carry of the add lands in the MSB as P shifts right.
                    w_p_nxt   = {w_cout, w_sum, r_p[WIDTH-1:1]};
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        w_p_nxt     = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_p_nxt     = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_busy    = 1'b0;
        o_product = '0;
        case (r_state)
            ST_IDLE: o_ready = 1'b1;
            ST_CALC: o_busy  = 1'b1;
            ST_DONE: begin
                o_valid   = 1'b1;
                o_product = r_p;
            end
            default: o_ready = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_mult_ctrl
//  Purpose  : Self-checking bench for shift_add_mult_ctrl with a WIDTH=4 and
//             a WIDTH=8 instance. Expected products are pushed to a queue at
//             the accept edge and popped when the product is observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult_ctrl;

    logic clk;
    logic rst_n;

    // WIDTH = 4 instance
    logic       v4, rdy4, clr4, ov4, ir4, busy4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    // WIDTH = 8 instance
    logic        v8, rdy8, clr8, ov8, ir8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int n_vec;
    int n_err;

    logic [7:0]  sb4[$];
    logic [15:0] sb8[$];

    shift_add_mult_ctrl #(.WIDTH(4)) u_dut4 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (v4),
        .o_ready   (rdy4),
        .i_a       (a4),
        .i_b       (b4),
        .i_clear   (clr4),
        .o_valid   (ov4),
        .i_ready   (ir4),
        .o_product (p4),
        .o_busy    (busy4)
    );

    shift_add_mult_ctrl #(.WIDTH(8)) u_dut8 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (v8),
        .o_ready   (rdy8),
        .i_a       (a8),
        .i_b       (b8),
        .i_clear   (clr8),
        .o_valid   (ov8),
        .i_ready   (ir8),
        .o_product (p8),
        .o_busy    (busy8)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    // Drives one operand pair into the WIDTH=4 DUT. Latency is the index of
    // the first falling edge after the accept edge at which o_valid is seen
    // (cycle 1 = the cycle right after the accept edge); 0 means timeout.
    task automatic txn4(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output logic [7:0] prod,
                        output logic calc_ok);
        lat     = 0;
        calc_ok = 1'b1;
        for (int w = 0; w < 20 && !rdy4; w++) @(negedge clk);
        v4 = 1'b1;
        a4 = a;
        b4 = b;
        sb4.push_back({4'b0, a} * {4'b0, b});
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            v4 = 1'b0;
            if (ov4) begin
                lat = c;
                break;
            end
            if (p4 !== 8'h00 || busy4 !== 1'b1) calc_ok = 1'b0;
        end
        prod = p4;
    endtask

    task automatic txn8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [15:0] prod,
                        output logic calc_ok);
        lat     = 0;
        calc_ok = 1'b1;
        for (int w = 0; w < 20 && !rdy8; w++) @(negedge clk);
        v8 = 1'b1;
        a8 = a;
        b8 = b;
        sb8.push_back({8'b0, a} * {8'b0, b});
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            v8 = 1'b0;
            if (ov8) begin
                lat = c;
                break;
            end
            if (p8 !== 16'h0000 || busy8 !== 1'b1) calc_ok = 1'b0;
        end
        prod = p8;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({rdy4, ov4, busy4, p4} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_w4: got rdy/val/busy/prod=%b%b%b/%h expected 100/00",
                     rdy4, ov4, busy4, p4);
        end
        n_vec++;
        if ({rdy8, ov8, busy8, p8} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_w8: got rdy/val/busy/prod=%b%b%b/%h expected 100/0000",
                     rdy8, ov8, busy8, p8);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic [7:0] prod; logic ok; logic [7:0] exp;
        ir4 = 1'b1;
        txn4(4'd3, 4'd5, lat, prod, ok);
        exp = sb4.pop_front();
        n_vec++;
        if (prod !== exp || exp !== 8'd15) begin
            n_err++;
            $display("FAIL basic_prod: got %h expected %h", prod, 8'd15);
        end
        n_vec++;
        if (lat !== 5) begin
            n_err++;
            $display("FAIL basic_latency: got %0d expected 5", lat);
        end
        n_vec++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL basic_calc: busy/product during CALC got bad, expected busy=1 prod=0");
        end
        @(negedge clk);
        n_vec++;
        if (rdy4 !== 1'b1 || ov4 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_release: got rdy=%b val=%b expected rdy=1 val=0", rdy4, ov4);
        end
    endtask

    task automatic test_corners4();
        int lat; logic [7:0] prod; logic ok; logic [7:0] exp;
        logic [3:0] ta[2];
        logic [3:0] tb[2];
        ta[0] = 4'hF; tb[0] = 4'hF;
        ta[1] = 4'h0; tb[1] = 4'hA;
        ir4 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            txn4(ta[i], tb[i], lat, prod, ok);
            exp = sb4.pop_front();
            n_vec++;
            if (prod !== exp) begin
                n_err++;
                $display("FAIL corner4_prod[%0d]: got %h expected %h", i, prod, exp);
            end
            n_vec++;
            if (lat !== 5) begin
                n_err++;
                $display("FAIL corner4_latency[%0d]: got %0d expected 5", i, lat);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat; logic [7:0] prod; logic ok; logic [7:0] exp;
        ir4 = 1'b0;
        txn4(4'd7, 4'd9, lat, prod, ok);
        exp = sb4.pop_front();
        n_vec++;
        if (prod !== exp || lat !== 5) begin
            n_err++;
            $display("FAIL bp_first: got prod=%h lat=%0d expected prod=%h lat=5", prod, lat, exp);
        end
        // Hold off the consumer and offer a new pair that must be ignored.
        v4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (p4 !== exp || ov4 !== 1'b1 || rdy4 !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got prod=%h val=%b rdy=%b expected %h/1/0",
                         i, p4, ov4, rdy4, exp);
            end
        end
        v4  = 1'b0;
        ir4 = 1'b1;
        @(negedge clk);
        n_vec++;
        if (rdy4 !== 1'b1 || ov4 !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: got rdy=%b val=%b expected rdy=1 val=0", rdy4, ov4);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat; logic [7:0] prod; logic ok; logic [7:0] exp;
        ir4 = 1'b1;
        v4 = 1'b1; a4 = 4'hC; b4 = 4'h3;
        @(posedge clk);
        @(negedge clk);
        v4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({rdy4, ov4, busy4, p4} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL async_reset: got rdy/val/busy/prod=%b%b%b/%h expected 100/00",
                     rdy4, ov4, busy4, p4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn4(4'hC, 4'h3, lat, prod, ok);
        exp = sb4.pop_front();
        n_vec++;
        if (prod !== exp || lat !== 5) begin
            n_err++;
            $display("FAIL post_reset: got prod=%h lat=%0d expected prod=%h lat=5", prod, lat, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_clear();
        int lat; logic [7:0] prod; logic ok; logic [7:0] exp;
        clr4 = 1'b1; v4 = 1'b1; a4 = 4'd2; b4 = 4'd2;
        @(negedge clk);
        n_vec++;
        if (rdy4 !== 1'b1 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL clear_idle: got rdy=%b busy=%b expected rdy=1 busy=0", rdy4, busy4);
        end
        clr4 = 1'b0; v4 = 1'b0;
        ir4 = 1'b0;
        txn4(4'd2, 4'd3, lat, prod, ok);
        exp = sb4.pop_front();
        n_vec++;
        if (prod !== exp) begin
            n_err++;
            $display("FAIL clear_prod: got %h expected %h", prod, exp);
        end
        clr4 = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ov4 !== 1'b0 || p4 !== 8'h00 || rdy4 !== 1'b1) begin
            n_err++;
            $display("FAIL clear_done: got val=%b prod=%h rdy=%b expected 0/00/1", ov4, p4, rdy4);
        end
        clr4 = 1'b0;
        ir4  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random8();
        int lat; logic [15:0] prod; logic ok; logic [15:0] exp;
        logic [7:0] a; logic [7:0] b;
        ir8 = 1'b1;
        for (int i = 0; i < 1002; i++) begin
            if (i == 0) begin
                a = 8'hFF; b = 8'hFF;
            end else if (i == 1) begin
                a = 8'h80; b = 8'h02;
            end else begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
            end
            txn8(a, b, lat, prod, ok);
            exp = sb8.pop_front();
            n_vec++;
            if (prod !== exp) begin
                n_err++;
                $display("FAIL rand8_prod[%0d]: %h*%h got %h expected %h", i, a, b, prod, exp);
            end
            n_vec++;
            if (lat !== 9) begin
                n_err++;
                $display("FAIL rand8_latency[%0d]: got %0d expected 9", i, lat);
            end
            n_vec++;
            if (ok !== 1'b1) begin
                n_err++;
                $display("FAIL rand8_calc[%0d]: busy/product during CALC wrong", i);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        n_vec = 0;
        n_err = 0;
        v4 = 1'b0; a4 = '0; b4 = '0; clr4 = 1'b0; ir4 = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; clr8 = 1'b0; ir8 = 1'b0;

        test_reset();
        test_basic();
        test_corners4();
        test_backpressure();
        test_reset_mid_calc();
        test_clear();
        test_random8();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
